// File: rtl/calc_seq_controller.sv
// ----------------------------------------------------------------------------
// calc_seq_controller
//
// Keypad-driven sequencer for a signed decimal calculator. Builds two
// two's-complement operands from digit strobes, latches an operator, and
// runs the operation on external adder/subtractor and multiplier units over
// start/done handshakes. Detects arithmetic overflow, supports negation,
// clear, and feeding a finished result into the next operation.
//
// Parameters:
//   WIDTH       operand/result width (two's complement)
//   MAX_DIGITS  maximum decimal digits accepted per operand
//
// Ports:
//   clk, RST                 clock (rising edge), asynchronous active-high reset
//   key_valid, key_digit     digit strobe and decimal digit (10-15 ignored)
//   op_valid, op_code        operator strobe; 000 add, 001 sub, 010 mul
//   equal, negate, clear     evaluate, sign toggle, return-to-start strobes
//   alu_start/sub/a/b        adder request; alu_done/alu_result its answer
//   mult_start/a/b           multiplier request; mult_done/mult_result answer
//   display_output           current entry, result in DONE, zero in ERROR
//   complete, busy, error    DONE, EXEC_ALU/EXEC_MUL, ERROR state flags
//
// Build macro:
//   CALC_CHAIN_EN  when defined, an operator pressed while entering operand2
//                  evaluates the pending operation and chains its result into
//                  operand1 of the newly selected operation.
// ----------------------------------------------------------------------------
module calc_seq_controller #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               key_valid,
    input  logic [3:0]         key_digit,
    input  logic               op_valid,
    input  logic [2:0]         op_code,
    input  logic               equal,
    input  logic               negate,
    input  logic               clear,
    output logic               alu_start,
    output logic               alu_sub,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic               alu_done,
    input  logic [WIDTH-1:0]   alu_result,
    output logic               mult_start,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    input  logic               mult_done,
    input  logic [2*WIDTH-1:0] mult_result,
    output logic [WIDTH-1:0]   display_output,
    output logic               complete,
    output logic               busy,
    output logic               error
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    // Extra headroom so entry*10 + digit never wraps before the range check.
    localparam int XW = WIDTH + 5;

    localparam logic signed [XW-1:0] TEN  = XW'(10);
    localparam logic signed [XW-1:0] MAXV = XW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] MINV = -MAXV;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;

    typedef enum logic [2:0] {
        ENTRY1,
        OP_WAIT,
        ENTRY2,
        EXEC_ALU,
        EXEC_MUL,
        DONE,
        ERROR
    } state_t;

    state_t                   state, state_n;
    logic signed [WIDTH-1:0]  op1, op1_n;
    logic signed [WIDTH-1:0]  op2, op2_n;
    logic signed [WIDTH-1:0]  result, result_n;
    logic                     neg, neg_n;
    logic [CW-1:0]            cnt, cnt_n;
    logic [2:0]               oper, oper_n;
`ifdef CALC_CHAIN_EN
    logic                     chain, chain_n;
    logic [2:0]               chain_op, chain_op_n;
`endif

    logic signed [XW-1:0]     cur_x;
    logic signed [XW-1:0]     dig_x;
    logic signed [XW-1:0]     cand;
    logic                     digit_ok;
    logic                     op_ok;
    logic                     exec_done;
    logic signed [WIDTH-1:0]  exec_res;
    logic                     exec_ovf;
    logic                     b_eff_sign;
    logic                     alu_ovf;
    logic                     mul_ovf;
    logic [WIDTH:0]           mul_top;

    // Candidate value of the active entry if the presented digit is accepted.
    // The digit is added or subtracted according to the entry's sign so that
    // a negated entry keeps growing in magnitude.
    always_comb begin
        if (state == ENTRY1) begin
            cur_x = op1;
        end else begin
            cur_x = op2;
        end
        dig_x    = {{(XW-4){1'b0}}, key_digit};
        cand     = neg ? (cur_x * TEN) - dig_x : (cur_x * TEN) + dig_x;
        digit_ok = (key_digit <= 4'd9) && (cnt < CW'(MAX_DIGITS)) &&
                   (cand <= MAXV) && (cand >= MINV);
        op_ok    = (op_code == OP_ADD) || (op_code == OP_SUB) || (op_code == OP_MUL);
    end

    // Completion and overflow of whichever unit is currently running.
    // Subtraction flips the effective sign of operand2 before the
    // same-sign/different-result test.
    always_comb begin
        b_eff_sign = op2[WIDTH-1] ^ (oper == OP_SUB);
        alu_ovf    = (op1[WIDTH-1] == b_eff_sign) && (alu_result[WIDTH-1] != op1[WIDTH-1]);
        mul_top    = mult_result[2*WIDTH-1:WIDTH-1];
        mul_ovf    = !((&mul_top) || !(|mul_top));
        if (state == EXEC_MUL) begin
            exec_done = mult_done;
            exec_res  = mult_result[WIDTH-1:0];
            exec_ovf  = mul_ovf;
        end else begin
            exec_done = alu_done;
            exec_res  = alu_result;
            exec_ovf  = alu_ovf;
        end
    end

    // Next-state logic. Strobe priority is clear > equal > op_valid > negate
    // > key_valid, and only the highest asserted strobe is considered even
    // when the current state ignores it.
    always_comb begin
        state_n  = state;
        op1_n    = op1;
        op2_n    = op2;
        neg_n    = neg;
        cnt_n    = cnt;
        oper_n   = oper;
        result_n = result;
`ifdef CALC_CHAIN_EN
        chain_n    = chain;
        chain_op_n = chain_op;
`endif
        if (clear) begin
            state_n  = ENTRY1;
            op1_n    = '0;
            op2_n    = '0;
            neg_n    = 1'b0;
            cnt_n    = '0;
            oper_n   = OP_ADD;
            result_n = '0;
`ifdef CALC_CHAIN_EN
            chain_n    = 1'b0;
            chain_op_n = OP_ADD;
`endif
        end else begin
            case (state)
                ENTRY1: begin
                    if (equal) begin
                        result_n = op1;
                        state_n  = DONE;
                    end else if (op_valid) begin
                        if (op_ok) begin
                            oper_n  = op_code;
                            op2_n   = '0;
                            neg_n   = 1'b0;
                            cnt_n   = '0;
                            state_n = OP_WAIT;
                        end
                    end else if (negate) begin
                        op1_n = -op1;
                        neg_n = ~neg;
                    end else if (key_valid && digit_ok) begin
                        op1_n = cand[WIDTH-1:0];
                        cnt_n = cnt + CW'(1);
                    end
                end
                OP_WAIT: begin
                    if (!equal) begin
                        if (op_valid) begin
                            if (op_ok) begin
                                oper_n = op_code;
                            end
                        end else if (negate) begin
                            op2_n = -op2;
                            neg_n = ~neg;
                        end else if (key_valid && digit_ok) begin
                            op2_n   = cand[WIDTH-1:0];
                            cnt_n   = cnt + CW'(1);
                            state_n = ENTRY2;
                        end
                    end
                end
                ENTRY2: begin
                    if (equal) begin
                        state_n = (oper == OP_MUL) ? EXEC_MUL : EXEC_ALU;
                    end else if (op_valid) begin
`ifdef CALC_CHAIN_EN
                        if (op_ok) begin
                            chain_n    = 1'b1;
                            chain_op_n = op_code;
                            state_n    = (oper == OP_MUL) ? EXEC_MUL : EXEC_ALU;
                        end
`endif
                    end else if (negate) begin
                        op2_n = -op2;
                        neg_n = ~neg;
                    end else if (key_valid && digit_ok) begin
                        op2_n = cand[WIDTH-1:0];
                        cnt_n = cnt + CW'(1);
                    end
                end
                EXEC_ALU, EXEC_MUL: begin
                    if (exec_done) begin
                        if (exec_ovf) begin
                            state_n = ERROR;
`ifdef CALC_CHAIN_EN
                            chain_n = 1'b0;
                        end else if (chain) begin
                            // Chained evaluation: result seeds operand1 and
                            // the operator pressed during ENTRY2 takes over.
                            op1_n   = exec_res;
                            oper_n  = chain_op;
                            op2_n   = '0;
                            neg_n   = 1'b0;
                            cnt_n   = '0;
                            chain_n = 1'b0;
                            state_n = OP_WAIT;
`endif
                        end else begin
                            result_n = exec_res;
                            state_n  = DONE;
                        end
                    end
                end
                DONE: begin
                    if (!equal) begin
                        if (op_valid) begin
                            if (op_ok) begin
                                op1_n   = result;
                                oper_n  = op_code;
                                op2_n   = '0;
                                neg_n   = 1'b0;
                                cnt_n   = '0;
                                state_n = OP_WAIT;
                            end
                        end else if (!negate && key_valid && (key_digit <= 4'd9)) begin
                            op1_n   = {{(WIDTH-4){1'b0}}, key_digit};
                            op2_n   = '0;
                            neg_n   = 1'b0;
                            cnt_n   = CW'(1);
                            state_n = ENTRY1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and registered outputs. Outputs are derived from the next-state
    // values so they line up with the state they describe; the start pulses
    // fire only on the cycle an EXEC state is entered.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state          <= ENTRY1;
            op1            <= '0;
            op2            <= '0;
            result         <= '0;
            neg            <= 1'b0;
            cnt            <= '0;
            oper           <= OP_ADD;
`ifdef CALC_CHAIN_EN
            chain          <= 1'b0;
            chain_op       <= OP_ADD;
`endif
            alu_start      <= 1'b0;
            alu_sub        <= 1'b0;
            alu_a          <= '0;
            alu_b          <= '0;
            mult_start     <= 1'b0;
            mult_a         <= '0;
            mult_b         <= '0;
            display_output <= '0;
            complete       <= 1'b0;
            busy           <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= state_n;
            op1            <= op1_n;
            op2            <= op2_n;
            result         <= result_n;
            neg            <= neg_n;
            cnt            <= cnt_n;
            oper           <= oper_n;
`ifdef CALC_CHAIN_EN
            chain          <= chain_n;
            chain_op       <= chain_op_n;
`endif
            alu_start      <= (state_n == EXEC_ALU) && (state != EXEC_ALU);
            alu_sub        <= (state_n == EXEC_ALU) && (oper_n == OP_SUB);
            alu_a          <= (state_n == EXEC_ALU) ? op1_n : '0;
            alu_b          <= (state_n == EXEC_ALU) ? op2_n : '0;
            mult_start     <= (state_n == EXEC_MUL) && (state != EXEC_MUL);
            mult_a         <= (state_n == EXEC_MUL) ? op1_n : '0;
            mult_b         <= (state_n == EXEC_MUL) ? op2_n : '0;
            complete       <= (state_n == DONE);
            busy           <= (state_n == EXEC_ALU) || (state_n == EXEC_MUL);
            error          <= (state_n == ERROR);
            case (state_n)
                DONE:    display_output <= result_n;
                ERROR:   display_output <= '0;
                ENTRY1:  display_output <= op1_n;
                default: display_output <= op2_n;
            endcase
        end
    end

endmodule

// File: doc/calc_seq_controller.md
Name: calc_seq_controller

Overview:
- Parametrised successor to the 16-bit calculator general controller.
- Collects signed decimal operands from keypad strobes and sequences add, subtract and multiply operations.
- Drives external adder/subtractor and multiplier units over start/done handshakes.
- Flags arithmetic overflow, supports sign negation and clear, and lets a result seed the next operation.

Parameters:
- WIDTH, 16: operand/result width, two's complement.
- MAX_DIGITS, 5: maximum decimal digits accepted per operand.

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- key_valid  in  1  one-cycle strobe: key_digit valid.
- key_digit  in  4  decimal digit 0-9; values 10-15 ignored.
- op_valid  in  1  one-cycle strobe: op_code valid.
- op_code  in  3  000 add, 001 sub, 010 mul; others ignored.
- equal  in  1  one-cycle evaluate strobe.
- negate  in  1  one-cycle strobe: two's-complement the current entry.
- clear  in  1  one-cycle strobe: return to initial state.
- alu_start  out  1  one-cycle start pulse to adder unit.
- alu_sub  out  1  1 = subtract; held valid while EXEC_ALU.
- alu_a, alu_b  out  WIDTH  adder operands; held while EXEC_ALU.
- alu_done  in  1  adder result valid this cycle; may coincide with alu_start.
- alu_result  in  WIDTH  adder result (alu_a ± alu_b, wrapping).
- mult_start  out  1  one-cycle start pulse to multiplier.
- mult_a, mult_b  out  WIDTH  multiplier operands; held while EXEC_MUL.
- mult_done  in  1  multiplier result valid; may coincide with start.
- mult_result  in  2*WIDTH  full signed product.
- display_output  out  WIDTH  current entry, or result in DONE.
- complete  out  1  high while in DONE.
- busy  out  1  high in EXEC_ALU/EXEC_MUL.
- error  out  1  high in ERROR.

Behaviour:
- Reset values: all outputs 0, state ENTRY1, operands and digit count 0.
- States:
  - ENTRY1 (build operand1)
  - OP_WAIT (operator latched, no operand2 digit yet)
  - ENTRY2
  - EXEC_ALU
  - EXEC_MUL
  - DONE
  - ERROR
- Input priority when several strobes arrive in one cycle: clear > equal > op_valid > negate > key_valid. Only the highest-priority strobe acts.
- Digit entry:
  - entry <= entry*10 ± digit; the sign follows entry's negated flag.
  - The digit is ignored if count = MAX_DIGITS or |result| > 2^(WIDTH-1)-1.
  - Accepted digits increment count.
- negate: toggles the sign of the current entry register. Allowed in ENTRY1, OP_WAIT (acts on operand2 = 0) and ENTRY2.
- op_valid:
  - ENTRY1 -> OP_WAIT.
  - OP_WAIT -> replace the latched operator.
  - DONE -> result becomes operand1, then OP_WAIT.
  - ENTRY2: see Optional Feature.
- First digit in OP_WAIT -> ENTRY2.
- equal:
  - ENTRY2 -> EXEC_ALU or EXEC_MUL per latched operator.
  - ENTRY1 -> DONE with result = operand1.
  - OP_WAIT, EXEC, DONE: ignored.
- EXEC timing:
  - alu_start/mult_start is high only in the first EXEC cycle.
  - Operands are stable for the whole EXEC state.
  - Result is captured in the cycle done=1; the next state is DONE or ERROR.
  - Latency: equal sampled at edge N, start high after edge N, complete high after edge N+1 if done is immediate.
- Overflow:
  - add/sub: operands have the same effective sign and the result sign differs -> ERROR.
  - mul: mult_result[2W-1:W-1] not all equal -> ERROR.
- DONE: display_output = result. key_valid starts a fresh ENTRY1 containing that digit.
- ERROR:
  - display_output = 0, error = 1.
  - Only clear or RST leaves it; all other strobes are ignored.
- clear in any state, including EXEC: state -> ENTRY1, registers zeroed, start outputs low. A late done is ignored.
- RST mid-operation: immediate asynchronous return to reset values.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined: op_valid in ENTRY2 evaluates the pending operation exactly as equal does. On success, the result becomes operand1, the new operator is latched and the state goes to OP_WAIT, with complete never asserting. Overflow -> ERROR.
- Undefined: op_valid in ENTRY2 is ignored.

Test Plan:
- Add: digits 1,2; op 000; digits 3,4; equal -> alu_start one cycle, complete=1, display_output=46.
- Signed mul: digit 7; op 010; digit 6; negate; equal -> mult_a=7, mult_b=-6, display_output=-42 (0xFFD6).
- Overflow: digits 3,2,7,6,7; op 000; digit 1; equal -> error=1, display_output=0. clear -> error=0, state ENTRY1.
- Digit limit (WIDTH=16): digits 9,9,9,9,9 -> display_output=9999, fifth digit rejected. Six 1s -> 11111.
- Chain (CALC_CHAIN_EN): 5 + 3 + 2 equal -> display_output=10. Without the macro the second + is ignored and the result is 5+32=37.
- Abort: start 4*5 with a delayed mult_done; clear during EXEC_MUL -> busy=0, later done ignored, display_output=0. RST during EXEC -> all outputs 0.
